vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_axis_counter.sv | 26 ++
 rtl/vga_timing_gen.sv | 91 +++++++++
 tb/tb_vga_timing_gen.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and coordinate type.
// Derived sync windows are half-open: [START, END).
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Free-running wrap counter for one scan axis; wrap is asserted on the
// enabled cycle that rolls TOTAL-1 back to 0.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL = 800
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       en,
    output logic [9:0] cnt,
    output logic       wrap
);

    assign wrap = en && (cnt == coord_t'(TOTAL - 1));

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (wrap)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 10'd1;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-rate VGA timing generator: scan counters plus a single register
// stage so coordinates, sync, blank and strobes always line up.
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_count
);
    import vga_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO = H_ACTIVE + H_FP;
    localparam int HS_HI = HS_LO + H_SYNC;
    localparam int VS_LO = V_ACTIVE + V_FP;
    localparam int VS_HI = VS_LO + V_SYNC;

    generate
        if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_timing
            $error("vga_timing_gen: H/V totals must fit 10-bit coordinates");
        end
    endgenerate

    coord_t hcnt, vcnt;
    logic   h_wrap, v_wrap;

    vga_axis_counter #(.TOTAL(H_TOT)) u_hcnt (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .en      (1'b1),
        .cnt     (hcnt),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOT)) u_vcnt (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .en      (h_wrap),
        .cnt     (vcnt),
        .wrap    (v_wrap)
    );

    logic blank_d, hs_d, vs_d, fs_d, vbs_d;

    always_comb begin
        blank_d = (hcnt < coord_t'(H_ACTIVE)) && (vcnt < coord_t'(V_ACTIVE));
        hs_d    = !((hcnt >= coord_t'(HS_LO)) && (hcnt < coord_t'(HS_HI)));
        vs_d    = !((vcnt >= coord_t'(VS_LO)) && (vcnt < coord_t'(VS_HI)));
        fs_d    = (hcnt == '0) && (vcnt == '0);
        vbs_d   = (hcnt == '0) && (vcnt == coord_t'(V_ACTIVE));
    end

    // frame_count advances on the same edge that registers frame_start
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX        <= '0;
            DrawY        <= '0;
            blank        <= 1'b0;
            hs           <= 1'b1;
            vs           <= 1'b1;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_count  <= '0;
        end else begin
            DrawX        <= hcnt;
            DrawY        <= vcnt;
            blank        <= blank_d;
            hs           <= hs_d;
            vs           <= vs_d;
            frame_start  <= fs_d;
            vblank_start <= vbs_d;
            frame_count  <= frame_count + {7'd0, fs_d};
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size generator for line-level timing, a shrunken
// instance (15x12 scan) for frame-level timing and frame_count wrap.
module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    logic       rst_a, rst_b;
    logic [9:0] ax, ay, bx, by;
    logic       ab, ahs, avs, afs, avb;
    logic       bb, bhs, bvs, bfs, bvb;
    logic [7:0] afc, bfc;

    int vec  = 0;
    int errs = 0;

    vga_timing_gen u_dut_a (
        .vga_clk      (vga_clk),
        .reset_n      (rst_a),
        .DrawX        (ax),
        .DrawY        (ay),
        .blank        (ab),
        .hs           (ahs),
        .vs           (avs),
        .frame_start  (afs),
        .vblank_start (avb),
        .frame_count  (afc)
    );

    // H: 8 active, hs low x=10..12, total 15. V: 6 active, vs low y=8..9, total 12.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_dut_b (
        .vga_clk      (vga_clk),
        .reset_n      (rst_b),
        .DrawX        (bx),
        .DrawY        (by),
        .blank        (bb),
        .hs           (bhs),
        .vs           (bvs),
        .frame_start  (bfs),
        .vblank_start (bvb),
        .frame_count  (bfc)
    );

    task automatic tick();
        @(posedge vga_clk);
        @(negedge vga_clk);
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) tick();
        vec++;
        if ({ax, ay, ab, ahs, avs, afs, avb, afc} !== {10'd0, 10'd0, 5'b01100, 8'd0}) begin
            errs++;
            $display("FAIL reset_a: got x=%0d y=%0d b/hs/vs/fs/vb=%b%b%b%b%b fc=%0d want 0 0 01100 0",
                     ax, ay, ab, ahs, avs, afs, avb, afc);
        end
        vec++;
        if ({bx, by, bb, bhs, bvs, bfs, bvb, bfc} !== {10'd0, 10'd0, 5'b01100, 8'd0}) begin
            errs++;
            $display("FAIL reset_b: got x=%0d y=%0d b/hs/vs/fs/vb=%b%b%b%b%b fc=%0d want 0 0 01100 0",
                     bx, by, bb, bhs, bvs, bfs, bvb, bfc);
        end
    endtask

    task automatic test_first_cycle();
        rst_a = 1'b1;
        tick();
        vec++;
        if ({ax, ay, ab, ahs, avs, afs, avb, afc} !== {10'd0, 10'd0, 5'b11110, 8'd1}) begin
            errs++;
            $display("FAIL first_cycle: got x=%0d y=%0d b/hs/vs/fs/vb=%b%b%b%b%b fc=%0d want 0 0 11110 1",
                     ax, ay, ab, ahs, avs, afs, avb, afc);
        end
    endtask

    task automatic test_line();
        int hs_low = 0;
        int blank_fall = -1;
        logic eb, ehs;
        for (int x = 1; x < 800; x++) begin
            tick();
            eb  = (x < 640);
            ehs = !(x >= 656 && x < 752);
            if (!ahs) hs_low++;
            if (!ab && blank_fall < 0) blank_fall = x;
            vec++;
            if ({ax, ay, ab, ahs, avs, afs, avb, afc} !== {10'(x), 10'd0, eb, ehs, 3'b100, 8'd1}) begin
                errs++;
                $display("FAIL line0 x=%0d: got x=%0d y=%0d b/hs/vs/fs/vb=%b%b%b%b%b fc=%0d want b=%b hs=%b vs=1 fs=0 vb=0 fc=1",
                         x, ax, ay, ab, ahs, avs, afs, avb, afc, eb, ehs);
            end
        end
        vec++;
        if (hs_low != 96) begin
            errs++;
            $display("FAIL hs_width: got %0d want 96", hs_low);
        end
        vec++;
        if (blank_fall != 640) begin
            errs++;
            $display("FAIL blank_fall: got x=%0d want 640", blank_fall);
        end
        tick();
        vec++;
        if ({ax, ay, ab, ahs, afs} !== {10'd0, 10'd1, 3'b110}) begin
            errs++;
            $display("FAIL line_wrap: got x=%0d y=%0d b=%b hs=%b fs=%b want 0 1 1 1 0",
                     ax, ay, ab, ahs, afs);
        end
    endtask

    task automatic test_reset_mid_a();
        int n = 0;
        while (!(ax == 10'd300 && ay == 10'd2) && n < 3000) begin
            tick();
            n++;
        end
        vec++;
        if (n >= 3000) begin
            errs++;
            $display("FAIL seek_a: got timeout at x=%0d y=%0d want x=300 y=2", ax, ay);
        end
        rst_a = 1'b0;
        #1;
        vec++;
        if ({ax, ay, ab, ahs, avs, afs, avb, afc} !== {10'd0, 10'd0, 5'b01100, 8'd0}) begin
            errs++;
            $display("FAIL async_reset_a: got x=%0d y=%0d b/hs/vs/fs/vb=%b%b%b%b%b fc=%0d want 0 0 01100 0",
                     ax, ay, ab, ahs, avs, afs, avb, afc);
        end
        repeat (3) tick();
        rst_a = 1'b1;
        tick();
        vec++;
        if ({ax, ay, ab, ahs, avs, afs, avb, afc} !== {10'd0, 10'd0, 5'b11110, 8'd1}) begin
            errs++;
            $display("FAIL restart_a: got x=%0d y=%0d b/hs/vs/fs/vb=%b%b%b%b%b fc=%0d want 0 0 11110 1",
                     ax, ay, ab, ahs, avs, afs, avb, afc);
        end
    endtask

    // Independent scan model for the small instance over two full frames.
    task automatic test_frames_b();
        logic [9:0] ex = '0, ey = '0;
        logic [7:0] efc = 8'd1;
        logic eb, ehs, evs, efs, evb;
        int last_fs = 0, vb_cnt = 0, vs_low = 0, fs_cnt = 0;
        rst_b = 1'b1;
        tick();
        vec++;
        if ({bx, by, bb, bhs, bvs, bfs, bvb, bfc} !== {10'd0, 10'd0, 5'b11110, 8'd1}) begin
            errs++;
            $display("FAIL first_cycle_b: got x=%0d y=%0d b/hs/vs/fs/vb=%b%b%b%b%b fc=%0d want 0 0 11110 1",
                     bx, by, bb, bhs, bvs, bfs, bvb, bfc);
        end
        for (int c = 1; c <= 360; c++) begin
            tick();
            if (ex == 10'd14) begin
                ex = '0;
                ey = (ey == 10'd11) ? 10'd0 : ey + 10'd1;
            end else begin
                ex = ex + 10'd1;
            end
            eb  = (ex < 10'd8) && (ey < 10'd6);
            ehs = !(ex >= 10'd10 && ex < 10'd13);
            evs = !(ey >= 10'd8 && ey < 10'd10);
            efs = (ex == 10'd0) && (ey == 10'd0);
            evb = (ex == 10'd0) && (ey == 10'd6);
            if (efs) efc = efc + 8'd1;
            if (bvb) vb_cnt++;
            if (!bvs) vs_low++;
            vec++;
            if ({bx, by, bb, bhs, bvs, bfs, bvb, bfc} !== {ex, ey, eb, ehs, evs, efs, evb, efc}) begin
                errs++;
                $display("FAIL frame_b c=%0d: got x=%0d y=%0d b/hs/vs/fs/vb=%b%b%b%b%b fc=%0d want x=%0d y=%0d %b%b%b%b%b fc=%0d",
                         c, bx, by, bb, bhs, bvs, bfs, bvb, bfc, ex, ey, eb, ehs, evs, efs, evb, efc);
            end
            if (bfs) begin
                fs_cnt++;
                vec++;
                if (c - last_fs != 180) begin
                    errs++;
                    $display("FAIL fs_period: got %0d want 180", c - last_fs);
                end
                last_fs = c;
            end
        end
        vec++;
        if (fs_cnt != 2 || vb_cnt != 2 || vs_low != 60 || bfc !== 8'd3) begin
            errs++;
            $display("FAIL frame_totals: got fs=%0d vb=%0d vs_low=%0d fc=%0d want 2 2 60 3",
                     fs_cnt, vb_cnt, vs_low, bfc);
        end
    endtask

    task automatic test_fc_wrap_b();
        logic [7:0] efc = 8'd3;
        logic saw_zero = 1'b0;
        for (int f = 0; f < 254; f++) begin
            repeat (180) tick();
            efc = efc + 8'd1;
            if (bfc == 8'd0 && bfs) saw_zero = 1'b1;
            vec++;
            if ({bfs, bfc} !== {1'b1, efc}) begin
                errs++;
                $display("FAIL fc_wrap f=%0d: got fs=%b fc=%0d want fs=1 fc=%0d", f, bfs, bfc, efc);
            end
        end
        vec++;
        if (!saw_zero) begin
            errs++;
            $display("FAIL fc_zero: got no 255->0 wrap want wrap to 0");
        end
    endtask

    task automatic test_reset_mid_b();
        int n = 0;
        while (!(bx == 10'd5 && by == 10'd4) && n < 400) begin
            tick();
            n++;
        end
        vec++;
        if (n >= 400) begin
            errs++;
            $display("FAIL seek_b: got timeout at x=%0d y=%0d want x=5 y=4", bx, by);
        end
        rst_b = 1'b0;
        #1;
        vec++;
        if ({bx, by, bb, bhs, bvs, bfs, bvb, bfc} !== {10'd0, 10'd0, 5'b01100, 8'd0}) begin
            errs++;
            $display("FAIL async_reset_b: got x=%0d y=%0d b/hs/vs/fs/vb=%b%b%b%b%b fc=%0d want 0 0 01100 0",
                     bx, by, bb, bhs, bvs, bfs, bvb, bfc);
        end
        repeat (3) tick();
        vec++;
        if ({bx, by, bfs, bfc} !== {10'd0, 10'd0, 1'b0, 8'd0}) begin
            errs++;
            $display("FAIL held_reset_b: got x=%0d y=%0d fs=%b fc=%0d want 0 0 0 0", bx, by, bfs, bfc);
        end
        rst_b = 1'b1;
        tick();
        vec++;
        if ({bx, by, bb, bhs, bvs, bfs, bvb, bfc} !== {10'd0, 10'd0, 5'b11110, 8'd1}) begin
            errs++;
            $display("FAIL restart_b: got x=%0d y=%0d b/hs/vs/fs/vb=%b%b%b%b%b fc=%0d want 0 0 11110 1",
                     bx, by, bb, bhs, bvs, bfs, bvb, bfc);
        end
    endtask

    initial begin
        test_reset();
        test_first_cycle();
        test_line();
        test_reset_mid_a();
        test_frames_b();
        test_fc_wrap_b();
        test_reset_mid_b();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
